// File: rtl/stack_pkg.sv
// Shared definitions for the stack-machine front end (fetch and execute).
//   - opcode constants OP_ADD..OP_CAR
//   - fetch FSM state encodings
//   - ins_t payload of one decoded instruction
//   - has_operand / is_illegal length helpers
package stack_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned STATE_W = 2;

    typedef logic [DATA_W-1:0] byte_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam byte_t OP_ADD = 8'd0;
    localparam byte_t OP_SUB = 8'd1;
    localparam byte_t OP_AND = 8'd2;
    localparam byte_t OP_ORR = 8'd3;
    localparam byte_t OP_XOR = 8'd4;
    localparam byte_t OP_NOT = 8'd5;
    localparam byte_t OP_DUP = 8'd6;
    localparam byte_t OP_DRP = 8'd7;
    localparam byte_t OP_PSI = 8'd8;
    localparam byte_t OP_PSH = 8'd9;
    localparam byte_t OP_STR = 8'd10;
    localparam byte_t OP_LDR = 8'd11;
    localparam byte_t OP_JPZ = 8'd12;
    localparam byte_t OP_JPN = 8'd13;
    localparam byte_t OP_FIN = 8'd14;
    localparam byte_t OP_JMP = 8'd15;
    localparam byte_t OP_CAL = 8'd16;
    localparam byte_t OP_RET = 8'd17;
    localparam byte_t OP_CAR = 8'd18;

    localparam logic [STATE_W-1:0] S_OPC   = 2'd0;
    localparam logic [STATE_W-1:0] S_OPR   = 2'd1;
    localparam logic [STATE_W-1:0] S_ISSUE = 2'd2;
    localparam logic [STATE_W-1:0] S_HALT  = 2'd3;

    typedef struct packed {
        byte_t opcode;
        byte_t operand;
        addr_t pc;
    } ins_t;

    // Two-byte instructions carry an immediate/address byte after the opcode.
    function automatic logic has_operand(input byte_t op);
        case (op)
            OP_PSI, OP_PSH, OP_STR, OP_JPZ, OP_JPN, OP_CAL, OP_CAR: has_operand = 1'b1;
            default:                                                has_operand = 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input byte_t op);
        is_illegal = (op > OP_CAR);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus bundle: program-memory port, instruction issue handshake,
// redirect input and halt status.
//   master : fetch_sequencer side
//   slave  : memory / execute side
// Optional: FETCH_ILLEGAL_TRAP_EN adds the illegal status flag.
interface fetch_sequencer_if;

    logic [stack_pkg::ADDR_W-1:0] mem_addr;
    logic [stack_pkg::DATA_W-1:0] mem_data;
    logic                         ins_valid;
    logic                         ins_ready;
    logic [stack_pkg::DATA_W-1:0] ins_opcode;
    logic [stack_pkg::DATA_W-1:0] ins_operand;
    logic [stack_pkg::ADDR_W-1:0] ins_pc;
    logic                         redirect_valid;
    logic [stack_pkg::ADDR_W-1:0] redirect_addr;
    logic                         halted;
`ifdef FETCH_ILLEGAL_TRAP_EN
    logic                         illegal;

    modport master (
        output mem_addr, input mem_data,
        output ins_valid, input ins_ready, output ins_opcode, ins_operand, ins_pc,
        input redirect_valid, redirect_addr,
        output halted, illegal
    );

    modport slave (
        input mem_addr, output mem_data,
        input ins_valid, output ins_ready, input ins_opcode, ins_operand, ins_pc,
        output redirect_valid, redirect_addr,
        input halted, illegal
    );
`else
    modport master (
        output mem_addr, input mem_data,
        output ins_valid, input ins_ready, output ins_opcode, ins_operand, ins_pc,
        input redirect_valid, redirect_addr,
        output halted
    );

    modport slave (
        input mem_addr, output mem_data,
        input ins_valid, output ins_ready, input ins_opcode, ins_operand, ins_pc,
        output redirect_valid, redirect_addr,
        input halted
    );
`endif

endinterface

// File: rtl/op_length_decode.sv
// Instruction length decode for the fetch FSM (combinational).
//   opcode      : byte currently on the program-memory read port
//   has_operand : opcode is followed by an operand byte
//   illegal     : opcode outside OP_ADD..OP_CAR (only with FETCH_ILLEGAL_TRAP_EN)
module op_length_decode
    import stack_pkg::*;
(
    input  byte_t opcode,
`ifdef FETCH_ILLEGAL_TRAP_EN
    output logic  illegal,
`endif
    output logic  has_operand
);

    assign has_operand = stack_pkg::has_operand(opcode);

`ifdef FETCH_ILLEGAL_TRAP_EN
    assign illegal = is_illegal(opcode);
`endif

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads opcode (and operand) bytes from a
// combinational program ROM, presents one instruction at a time on a
// valid/ready handshake, follows redirects, and stops after FIN retires.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_sequencer_if.master (memory, issue, redirect, halted)
// Optional: FETCH_ILLEGAL_TRAP_EN halts on an out-of-range opcode and raises illegal.
module fetch_sequencer
    import stack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);

    logic [STATE_W-1:0] state_q, state_d;
    addr_t              pc_q, pc_d;
    ins_t               ins_q, ins_d;
    logic               ins_valid_q, ins_valid_d;
    logic               halted_q, halted_d;
    logic               has_opr_c;

`ifdef FETCH_ILLEGAL_TRAP_EN
    logic               illegal_q, illegal_d;
    logic               illegal_c;
`endif

    op_length_decode u_op_length_decode (
        .opcode      (bus.mem_data),
`ifdef FETCH_ILLEGAL_TRAP_EN
        .illegal     (illegal_c),
`endif
        .has_operand (has_opr_c)
    );

    // Next-state logic; a redirect overrides everything except halt.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif

        case (state_q)
            S_OPC: begin
                ins_d.opcode  = bus.mem_data;
                ins_d.operand = '0;
                ins_d.pc      = pc_q;
                pc_d          = pc_q + ADDR_W'(1);
`ifdef FETCH_ILLEGAL_TRAP_EN
                if (illegal_c) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else
`endif
                state_d = has_opr_c ? S_OPR : S_ISSUE;
            end
            S_OPR: begin
                ins_d.operand = bus.mem_data;
                pc_d          = pc_q + ADDR_W'(1);
                state_d       = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.ins_ready) begin
                    state_d = (ins_q.opcode == OP_FIN) ? S_HALT : S_OPC;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_OPC;
            end
        endcase

        // Discards any partial or un-handshaked instruction; beats FIN on a handshake.
        if (bus.redirect_valid && (state_q != S_HALT)) begin
            pc_d    = bus.redirect_addr;
            state_d = S_OPC;
`ifdef FETCH_ILLEGAL_TRAP_EN
            illegal_d = 1'b0;
`endif
        end

        ins_valid_d = (state_d == S_ISSUE);
        halted_d    = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_OPC;
            pc_q        <= '0;
            ins_q       <= '0;
            ins_valid_q <= 1'b0;
            halted_q    <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
            halted_q    <= halted_d;
`ifdef FETCH_ILLEGAL_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    // ROM is read-only, so the address simply tracks pc in every state.
    assign bus.mem_addr    = pc_q;
    assign bus.ins_valid   = ins_valid_q;
    assign bus.ins_opcode  = ins_q.opcode;
    assign bus.ins_operand = ins_q.operand;
    assign bus.ins_pc      = ins_q.pc;
    assign bus.halted      = halted_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
    assign bus.illegal     = illegal_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed programs in a behavioural
// ROM, an expected-instruction queue filled by the stimulus, and a monitor
// that pops and compares on every issue handshake.
module tb_fetch_sequencer;
    import stack_pkg::*;

    logic clk = 1'b0;
    logic rst;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    assign bus.mem_data = mem[bus.mem_addr];

    int   errors = 0;
    int   checks = 0;
    ins_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input byte_t op, input byte_t opr, input addr_t pc);
        ins_t e;
        e.opcode  = op;
        e.operand = opr;
        e.pc      = pc;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted instruction must match the head of the queue.
    always @(negedge clk) begin
        ins_t e;
        if (!rst && bus.ins_valid && bus.ins_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected: got op=%0h opr=%0h pc=%0h expected none",
                         bus.ins_opcode, bus.ins_operand, bus.ins_pc);
            end else begin
                e = exp_q.pop_front();
                chk("issue", 32'({bus.ins_opcode, bus.ins_operand, bus.ins_pc}), 32'(e));
            end
        end
    end

    task automatic wait_issue(input addr_t pc, input int max);
        int n = 0;
        @(negedge clk);
        while (!(bus.ins_valid && bus.ins_pc == pc) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_issue_%0h", pc), 32'(bus.ins_valid && bus.ins_pc == pc), 32'd1);
    endtask

    task automatic wait_fetch(input addr_t addr, input int max);
        int n = 0;
        @(negedge clk);
        while (!(bus.mem_addr == addr && !bus.ins_valid) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_fetch_%0h", addr), 32'(bus.mem_addr == addr && !bus.ins_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus.ins_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;

        // Phase A: main program
        mem[0]  = 8'd8;  mem[1]  = 8'd10;
        mem[2]  = 8'd9;  mem[3]  = 8'h33;
        mem[4]  = 8'd0;
        mem[5]  = 8'd1;
        mem[6]  = 8'd10; mem[7]  = 8'h77;
        mem[8]  = 8'd17;
        mem[9]  = 8'd18; mem[10] = 8'hAA;
        mem[11] = 8'd2;
        mem[12] = 8'd3;
        mem[13] = 8'd12; mem[14] = 8'h05;
        mem[15] = 8'd13; mem[16] = 8'h40;
        mem[21] = 8'd8;  mem[22] = 8'h5A;
        mem[23] = 8'd16; mem[24] = 8'hC0;
        mem[25] = 8'd9;  mem[26] = 8'h99;
        mem[27] = 8'd4;
        mem[28] = 8'd5;
        mem[29] = 8'd14;

        push(8'd8,  8'd10, 8'd0);
        push(8'd9,  8'h33, 8'd2);
        push(8'd0,  8'h00, 8'd4);
        push(8'd1,  8'h00, 8'd5);
        push(8'd10, 8'h77, 8'd6);
        push(8'd17, 8'h00, 8'd8);
        push(8'd18, 8'hAA, 8'd9);
        push(8'd2,  8'h00, 8'd11);
        push(8'd3,  8'h00, 8'd12);
        push(8'd12, 8'h05, 8'd13);
        push(8'd13, 8'h40, 8'd15);
        push(8'd8,  8'h5A, 8'd21);
        push(8'd16, 8'hC0, 8'd23);
        push(8'd4,  8'h00, 8'd27);
        push(8'd5,  8'h00, 8'd28);
        push(8'd14, 8'h00, 8'd29);

        repeat (2) @(negedge clk);
        chk("rst_mem_addr",  32'(bus.mem_addr),    32'd0);
        chk("rst_valid",     32'(bus.ins_valid),   32'd0);
        chk("rst_halted",    32'(bus.halted),      32'd0);
        chk("rst_opcode",    32'(bus.ins_opcode),  32'd0);
        chk("rst_operand",   32'(bus.ins_operand), 32'd0);
        chk("rst_ins_pc",    32'(bus.ins_pc),      32'd0);

        bus.ins_ready = 1'b1;
        rst           = 1'b0;

        @(negedge clk);
        chk("first_opr_valid", 32'(bus.ins_valid), 32'd0);
        chk("first_opr_addr",  32'(bus.mem_addr),  32'd1);
        @(negedge clk);
        chk("first_valid",   32'(bus.ins_valid),   32'd1);
        chk("first_opcode",  32'(bus.ins_opcode),  32'd8);
        chk("first_operand", 32'(bus.ins_operand), 32'd10);
        chk("first_ins_pc",  32'(bus.ins_pc),      32'd0);

        // Single-byte ADD at 4: valid one cycle after its opcode fetch.
        wait_fetch(8'd4, 20);
        @(negedge clk);
        chk("add_valid",   32'(bus.ins_valid),   32'd1);
        chk("add_ins_pc",  32'(bus.ins_pc),      32'd4);
        chk("add_operand", 32'(bus.ins_operand), 32'd0);

        // Back-pressure on the instruction at 5.
        @(posedge clk); #1 bus.ins_ready = 1'b0;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid",    32'(bus.ins_valid),  32'd1);
            chk("stall_opcode",   32'(bus.ins_opcode), 32'd1);
            chk("stall_ins_pc",   32'(bus.ins_pc),     32'd5);
            chk("stall_mem_addr", 32'(bus.mem_addr),   32'd6);
        end
        @(posedge clk); #1 bus.ins_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("resume_valid", 32'(bus.ins_valid), 32'd0);
        chk("resume_addr",  32'(bus.mem_addr),  32'd6);

        // Redirect at the JPN handshake.
        wait_issue(8'd15, 60);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'd21;
        @(posedge clk); #1 bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("jpn_redirect_addr",  32'(bus.mem_addr),  32'd21);
        chk("jpn_redirect_valid", 32'(bus.ins_valid), 32'd0);
        wait_issue(8'd21, 10);
        chk("jpn_target_opcode", 32'(bus.ins_opcode), 32'd8);

        // Redirect during the operand fetch of PSH at 25 drops it.
        wait_fetch(8'd26, 40);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'd27;
        @(posedge clk); #1 bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("discard_addr",  32'(bus.mem_addr),  32'd27);
        chk("discard_valid", 32'(bus.ins_valid), 32'd0);

        // FIN at 29 halts; redirects are then ignored.
        wait_issue(8'd29, 20);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fin_halted",   32'(bus.halted),    32'd1);
        chk("fin_valid",    32'(bus.ins_valid), 32'd0);
        chk("fin_mem_addr", 32'(bus.mem_addr),  32'd30);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'h40;
        repeat (3) begin
            @(negedge clk);
            chk("halt_hold",  32'(bus.halted),    32'd1);
            chk("halt_valid", 32'(bus.ins_valid), 32'd0);
            chk("halt_addr",  32'(bus.mem_addr),  32'd30);
        end
        @(posedge clk); #1 bus.redirect_valid = 1'b0;
        chk("drain_a", 32'(exp_q.size()), 32'd0);

        rst = 1'b1;
        #1;
        chk("async_rst_addr",   32'(bus.mem_addr), 32'd0);
        chk("async_rst_halted", 32'(bus.halted),   32'd0);

        // Phase B: pc wrap through 255 and redirect beating FIN.
        mem[0]   = 8'd17;
        mem[1]   = 8'd14;
        mem[2]   = 8'd1;
        mem[255] = 8'd8;
        mem[80]  = 8'd3;
        mem[81]  = 8'd14;
        push(8'd17, 8'h00, 8'd0);
        push(8'd8,  8'd17, 8'd255);
        push(8'd14, 8'h00, 8'd1);
        push(8'd3,  8'h00, 8'd80);
        push(8'd14, 8'h00, 8'd81);

        @(negedge clk) rst = 1'b0;
        wait_issue(8'd0, 5);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'd255;
        @(posedge clk); #1 bus.redirect_valid = 1'b0;
        wait_issue(8'd255, 10);
        chk("wrap_operand", 32'(bus.ins_operand), 32'd17);
        chk("wrap_pc",      32'(bus.mem_addr),    32'd1);
        wait_issue(8'd1, 10);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'd80;
        @(posedge clk); #1 bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("fin_redirect_halted", 32'(bus.halted),   32'd0);
        chk("fin_redirect_addr",   32'(bus.mem_addr), 32'd80);
        wait_issue(8'd81, 10);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fin2_halted", 32'(bus.halted), 32'd1);
        chk("drain_b", 32'(exp_q.size()), 32'd0);

        // Phase C: out-of-range opcode at 0.
        rst    = 1'b1;
        mem[0] = 8'hFF;
        mem[1] = 8'h00;
`ifndef FETCH_ILLEGAL_TRAP_EN
        push(8'hFF, 8'h00, 8'd0);
`endif
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
`ifdef FETCH_ILLEGAL_TRAP_EN
        chk("trap_illegal", 32'(bus.illegal),   32'd1);
        chk("trap_halted",  32'(bus.halted),    32'd1);
        chk("trap_valid",   32'(bus.ins_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("trap_hold_valid", 32'(bus.ins_valid), 32'd0);
        end
`else
        chk("ff_valid",   32'(bus.ins_valid),   32'd1);
        chk("ff_opcode",  32'(bus.ins_opcode),  32'hFF);
        chk("ff_operand", 32'(bus.ins_operand), 32'd0);
        chk("ff_halted",  32'(bus.halted),      32'd0);
`endif
        @(posedge clk); #1;
        chk("drain_c", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
